// File: rtl/async_rst_fifo_pkg.sv
// Shared defaults for the single-clock show-ahead FIFO.
// Depth is 2**ASIZE words of DSIZE bits.
package async_rst_fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

endpackage

// File: rtl/async_rst_fifo_if.sv
// Producer/consumer bundle for async_rst_fifo.
// The FIFO is the slave; its user is the master.
interface async_rst_fifo_if
  import async_rst_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
);

  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic [ASIZE:0]   count;

  modport master (
    output winc, wdata, rinc,
    input  wfull, rdata, rempty, count
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, rdata, rempty, count
  );

endinterface

// File: rtl/async_rst_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem
  import async_rst_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/async_rst_fifo.sv
// Single-clock show-ahead FIFO with async active-high reset.
// Flags and count are registered from next-state pointers.
module async_rst_fifo
  import async_rst_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic           clk,
  input  logic           rst,
  async_rst_fifo_if.slave bus
);

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic           wfull_q, wfull_d;
  logic           rempty_q, rempty_d;
  logic           we, re;

  assign we = bus.winc & ~wfull_q;
  assign re = bus.rinc & ~rempty_q;

  always_comb begin
    wptr_d   = wptr_q + {{ASIZE{1'b0}}, we};
    rptr_d   = rptr_q + {{ASIZE{1'b0}}, re};
    rempty_d = (wptr_d == rptr_d);
    // Wrap bits differ with equal addresses: writer is a lap ahead
    wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
               (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    count_d  = wptr_d - rptr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q[ASIZE-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[ASIZE-1:0]),
    .rdata_o (bus.rdata)
  );

  assign bus.wfull  = wfull_q;
  assign bus.rempty = rempty_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_async_rst_fifo.sv
// Directed bench for async_rst_fifo: reset, fill, overflow,
// drain, wrap/concurrency and mid-operation reset.
module tb_async_rst_fifo;

  logic clk;
  logic rst;
  int   ncmp;
  int   nerr;

  async_rst_fifo_if #(.DSIZE(8), .ASIZE(4)) bus ();

  async_rst_fifo #(
    .DSIZE (8),
    .ASIZE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_state(input string tag,
                           input int cnt,
                           input logic full,
                           input logic empty);
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".wfull"}, 32'(bus.wfull), 32'(full));
    chk({tag, ".rempty"}, 32'(bus.rempty), 32'(empty));
  endtask

  initial begin
    ncmp      = 0;
    nerr      = 0;
    rst       = 1'b1;
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    bus.wdata = '0;

    // Reset held two cycles, then released
    tick();
    tick();
    chk_state("reset", 0, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    chk_state("post_reset", 0, 1'b0, 1'b1);

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      bus.winc  = 1'b1;
      bus.wdata = 8'(i);
      tick();
      chk("fill.count", 32'(bus.count), 32'(i));
      chk("fill.rdata", 32'(bus.rdata), 32'd1);
      chk("fill.rempty", 32'(bus.rempty), 32'd0);
    end
    chk_state("full", 16, 1'b1, 1'b0);

    // Overflow write is dropped
    bus.wdata = 8'd99;
    tick();
    bus.winc = 1'b0;
    chk_state("overflow", 16, 1'b1, 1'b0);

    // Drain with 4 extra reads on empty
    bus.rinc = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 16) chk("drain.rdata", 32'(bus.rdata), 32'(k));
      tick();
      if (k <= 16) chk("drain.count", 32'(bus.count), 32'(16 - k));
    end
    bus.rinc = 1'b0;
    chk_state("drained", 0, 1'b0, 1'b1);

    // Preload 8 words, then 24 cycles of read+write across the wrap
    bus.winc = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bus.wdata = 8'(100 + j);
      tick();
    end
    chk_state("pre8", 8, 1'b0, 1'b0);
    bus.rinc = 1'b1;
    for (int j = 0; j < 24; j++) begin
      bus.wdata = 8'(108 + j);
      chk("wrap.rdata", 32'(bus.rdata), 32'(100 + j));
      tick();
      chk("wrap.count", 32'(bus.count), 32'd8);
    end
    bus.rinc = 1'b0;
    chk("wrap.head", 32'(bus.rdata), 32'd124);

    // Top up to full: 132..139
    for (int j = 0; j < 8; j++) begin
      bus.wdata = 8'(132 + j);
      tick();
    end
    chk_state("refull", 16, 1'b1, 1'b0);

    // Read+write while full: only the read happens
    bus.rinc  = 1'b1;
    bus.wdata = 8'd200;
    tick();
    bus.winc = 1'b0;
    chk_state("rw_full", 15, 1'b0, 1'b0);
    chk("rw_full.rdata", 32'(bus.rdata), 32'd125);

    // Drain remaining 125..139; dropped 200 must not appear
    for (int j = 0; j < 15; j++) begin
      chk("drain2.rdata", 32'(bus.rdata), 32'(125 + j));
      tick();
    end
    chk_state("drained2", 0, 1'b0, 1'b1);

    // Read+write while empty: only the write happens
    bus.winc  = 1'b1;
    bus.wdata = 8'd55;
    tick();
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    chk_state("rw_empty", 1, 1'b0, 1'b0);
    chk("rw_empty.rdata", 32'(bus.rdata), 32'd55);

    // Grow to 5 entries, then reset between edges
    bus.winc = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus.wdata = 8'(60 + j);
      tick();
    end
    bus.winc = 1'b0;
    chk_state("five", 5, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    chk_state("rst_hold", 0, 1'b0, 1'b1);
    bus.winc  = 1'b1;
    bus.wdata = 8'd7;
    tick();
    bus.winc = 1'b0;
    chk_state("after_rst", 1, 1'b0, 1'b0);
    chk("after_rst.rdata", 32'(bus.rdata), 32'd7);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    chk_state("final", 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
